// File: rtl/sbox_cfg_pkg.sv
// Shared types and constants for the switch-box configuration loader.
package sbox_cfg_pkg;

    localparam int unsigned WORD_W    = 6;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        SIDE_NONE   = 3'd0,
        SIDE_TOP    = 3'd1,
        SIDE_RIGHT  = 3'd2,
        SIDE_BOTTOM = 3'd3,
        SIDE_LEFT   = 3'd4
    } side_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_CSUM,
        ST_CHECK,
        ST_ERROR
    } state_e;

    // One pin's routing word: source pin index above source side.
    typedef struct packed {
        logic [2:0] idx;
        side_e      side;
    } cfg_word_t;

endpackage

// File: rtl/sbox_word_check.sv
// Flags any shadow word whose side field is not a defined side code.
module sbox_word_check
    import sbox_cfg_pkg::*;
#(
    parameter int unsigned NW = 18,
    parameter int unsigned WW = WORD_W
) (
    input  logic [NW*WW-1:0] words_i,
    output logic             illegal_c_o
);

    cfg_word_t w;

    always_comb begin
        illegal_c_o = 1'b0;
        w           = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            w = cfg_word_t'(words_i[i*WW +: WORD_W]);
            if (w.side > SIDE_LEFT) begin
                illegal_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sbox_cfg_loader.sv
// Serial bitstream loader for the switch-box matrix: sync byte, shadow words,
// checksum, then an atomic commit of the shadow into cfg_active.
module sbox_cfg_loader
    import sbox_cfg_pkg::*;
#(
    parameter int unsigned NH = 5,
    parameter int unsigned NV = 4,
    parameter int unsigned WW = WORD_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_start,
    input  logic                        cfg_valid,
    input  logic                        cfg_bit,
    output logic                        cfg_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [(2*NH+2*NV)*WW-1:0]   cfg_active
);

    localparam int unsigned NWORDS = 2*NH + 2*NV;
    localparam int unsigned CFG_W  = NWORDS * WW;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned WB_W   = $clog2(WW);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WB_W-1:0]    wbit_q, wbit_d;
    logic [WW-2:0]      word_q, word_d;
    logic [7:0]         rx_q, rx_d;
    logic [7:0]         acc_q, acc_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   active_q, active_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               fire;
    logic               illegal;
    logic [7:0]         rx_shift;
    logic [WW-1:0]      word_full;

    assign fire      = cfg_valid && ready_q;
    assign rx_shift  = {rx_q[6:0], cfg_bit};
    assign word_full = {word_q, cfg_bit};

    sbox_word_check #(
        .NW (NWORDS),
        .WW (WW)
    ) u_word_check (
        .words_i     (shadow_q),
        .illegal_c_o (illegal)
    );

    // Completed words shift in from the top so the first word lands at [WW-1:0].
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wbit_d   = wbit_q;
        word_d   = word_q;
        rx_d     = rx_q;
        acc_d    = acc_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;

        if (fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (cfg_start) begin
            state_d = ST_SYNC;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                ST_SYNC: begin
                    if (fire) begin
                        rx_d = rx_shift;
                        if (cnt_q == CNT_W'(7)) begin
                            state_d = (rx_shift == SYNC_BYTE) ? ST_DATA : ST_ERROR;
                        end
                    end
                end
                ST_DATA: begin
                    if (fire) begin
                        word_d = word_full[WW-2:0];
                        wbit_d = wbit_q + WB_W'(1);
                        if (wbit_q == WB_W'(WW-1)) begin
                            wbit_d   = '0;
                            shadow_d = {word_full, shadow_q[CFG_W-1:WW]};
                            acc_d    = acc_q + 8'(word_full);
                        end
                        if (cnt_q == CNT_W'(CFG_W-1)) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (fire) begin
                        rx_d = rx_shift;
                        if (cnt_q == CNT_W'(7)) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if ((rx_q == acc_q) && !illegal) begin
                        active_d = shadow_q;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_ERROR;
                    end
                end
                default: ;
            endcase
        end

        if (cfg_start || (state_d != state_q)) begin
            cnt_d  = '0;
            wbit_d = '0;
        end

        ready_d = (state_d == ST_SYNC) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        busy_d  = ready_d || (state_d == ST_CHECK);
        err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wbit_q   <= '0;
            word_q   <= '0;
            rx_q     <= '0;
            acc_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wbit_q   <= wbit_d;
            word_q   <= word_d;
            rx_q     <= rx_d;
            acc_q    <= acc_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cfg_active = active_q;

endmodule

// File: tb/tb_sbox_cfg_loader.sv
// Directed frame-table bench for sbox_cfg_loader plus abort and reset sequences.
module tb_sbox_cfg_loader;

    localparam int unsigned NW = 18;
    localparam int unsigned CW = 108;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] cfg_active;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    typedef struct {
        string         name;
        logic [7:0]    sync;
        logic [CW-1:0] words;
        logic [7:0]    csum;
        logic          exp_done;
        logic          exp_err;
        bit            gaps;
    } vec_t;

    vec_t vecs[7];

    sbox_cfg_loader #(.NH(5), .NV(4), .WW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cfg_active (cfg_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshaked bit; optional random idle cycles before it.
    task automatic xfer(input logic b, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                cfg_valid = 1'b0;
                tick();
            end
        end
        cfg_valid = 1'b1;
        cfg_bit   = b;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check1("ready_timeout", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) xfer(v[i], gaps);
    endtask

    // First nbits of the data stream: word 0 first, each word MSB-first.
    task automatic send_words(input logic [CW-1:0] w, input int nbits, input bit gaps);
        int sent;
        sent = 0;
        for (int k = 0; k < int'(NW); k++) begin
            for (int b = 5; b >= 0; b--) begin
                if (sent < nbits) xfer(w[k*6 + b], gaps);
                sent++;
            end
        end
    endtask

    task automatic pulse_start(input logic with_bit);
        cfg_start = 1'b1;
        cfg_valid = with_bit;
        cfg_bit   = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    function automatic logic [7:0] csum_of(input logic [CW-1:0] w);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < int'(NW); i++) s = s + {2'b00, w[i*6 +: 6]};
        return s;
    endfunction

    initial begin
        logic [CW-1:0] model_active;
        logic [CW-1:0] w;
        int            d0;
        int            cnt;

        w = {18{6'h01}};
        vecs[0] = '{"bad_sync",     8'hA4, w, 8'h12, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"nominal",      8'hA5, w, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"bad_csum",     8'hA5, w, 8'h13, 1'b0, 1'b1, 1'b0};
        w[7*6 +: 6] = 6'b000_101;
        vecs[3] = '{"illegal_side", 8'hA5, w, 8'h16, 1'b0, 1'b1, 1'b0};
        w = {18{6'b111_100}};
        vecs[4] = '{"side4_max",    8'hA5, w, 8'h38, 1'b1, 1'b0, 1'b1};
        w = {18{6'h01}};
        w[17*6 +: 6] = 6'b000_111;
        vecs[5] = '{"side7_last",   8'hA5, w, 8'h18, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < int'(NW); i++) w[i*6 +: 6] = {3'(i % 8), 3'(i % 5)};
        vecs[6] = '{"mixed",        8'hA5, w, csum_of(w), 1'b1, 1'b0, 1'b1};

        model_active = '0;

        #12;
        check1("rst_ready", cfg_ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        checkw("rst_active", cfg_active, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[v]) begin
            d0 = done_cnt;
            pulse_start(1'b0);
            check1({vecs[v].name, ".start_busy"}, busy, 1'b1);
            check1({vecs[v].name, ".start_ready"}, cfg_ready, 1'b1);
            check1({vecs[v].name, ".start_err"}, err, 1'b0);
            send_byte(vecs[v].sync, vecs[v].gaps);
            if (vecs[v].sync != 8'hA5) begin
                check1({vecs[v].name, ".err"}, err, vecs[v].exp_err);
                check1({vecs[v].name, ".busy"}, busy, 1'b0);
                cnt = 0;
                cfg_valid = 1'b1;
                repeat (10) begin
                    tick();
                    if (cfg_ready === 1'b1) cnt++;
                end
                cfg_valid = 1'b0;
                checki({vecs[v].name, ".ignored"}, cnt, 0);
            end else begin
                send_words(vecs[v].words, int'(CW), vecs[v].gaps);
                send_byte(vecs[v].csum, vecs[v].gaps);
                check1({vecs[v].name, ".chk_busy"}, busy, 1'b1);
                check1({vecs[v].name, ".chk_ready"}, cfg_ready, 1'b0);
                tick();
                check1({vecs[v].name, ".done"}, done, vecs[v].exp_done);
                check1({vecs[v].name, ".err"}, err, vecs[v].exp_err);
                check1({vecs[v].name, ".busy"}, busy, 1'b0);
            end
            if (vecs[v].exp_done) model_active = vecs[v].words;
            checkw({vecs[v].name, ".active"}, cfg_active, model_active);
            tick();
            check1({vecs[v].name, ".done_end"}, done, 1'b0);
            checki({vecs[v].name, ".done_cnt"}, done_cnt - d0, int'(vecs[v].exp_done));
        end

        // Abort mid-DATA; restart pulse arrives with a valid bit that must be dropped.
        d0 = done_cnt;
        pulse_start(1'b0);
        send_byte(8'hA5, 1'b0);
        send_words({18{6'h0A}}, 50, 1'b0);
        checkw("abort.mid_active", cfg_active, model_active);
        pulse_start(1'b1);
        check1("abort.restart_busy", busy, 1'b1);
        send_byte(8'hA5, 1'b0);
        send_words({18{6'h13}}, int'(CW), 1'b0);
        send_byte(8'h56, 1'b0);
        tick();
        tick();
        model_active = {18{6'h13}};
        checki("abort.done_cnt", done_cnt - d0, 1);
        checkw("abort.active", cfg_active, model_active);
        check1("abort.err", err, 1'b0);

        // Asynchronous reset in the middle of DATA.
        pulse_start(1'b0);
        send_byte(8'hA5, 1'b0);
        send_words({18{6'h02}}, 30, 1'b0);
        cfg_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check1("arst.ready", cfg_ready, 1'b0);
        check1("arst.busy", busy, 1'b0);
        check1("arst.done", done, 1'b0);
        check1("arst.err", err, 1'b0);
        checkw("arst.active", cfg_active, '0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (3) begin
            tick();
            if (cfg_ready === 1'b1 || busy === 1'b1) cnt++;
        end
        cfg_valid = 1'b0;
        checki("arst.idle", cnt, 0);
        checkw("arst.active_hold", cfg_active, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sbox_cfg_loader.md
SBOX_CFG_LOADER -- requirements
Module: sbox_cfg_loader

Interface
REQ-001 The block SHALL have parameter NH, default 5, meaning the number of pins per top/bottom side.
REQ-002 The block SHALL have parameter NV, default 4, meaning the number of pins per left/right side.
REQ-003 The block SHALL have parameter WW, default 6, meaning the config word width: [5:3] source index, [2:0] source side.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port cfg_start, input, 1 bit: single-cycle pulse that begins a load.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: cfg_bit is valid this cycle.
REQ-008 The block SHALL have port cfg_bit, input, 1 bit: serial bitstream data, MSB-first.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit: loader accepts a bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse on successful commit.
REQ-012 The block SHALL have port err, output, 1 bit: sticky load failure.
REQ-013 The block SHALL have port cfg_active, output, (2*NH+2*NV)*WW bits (108 by default): committed switch-matrix config.

Function
REQ-014 The block SHALL transfer a bit only on a cycle where cfg_valid and cfg_ready are both 1.
REQ-015 The block SHALL implement states IDLE, SYNC, DATA, CSUM, CHECK and ERROR.
REQ-016 IDLE: cfg_ready=0 and busy=0; cfg_start SHALL move the FSM to SYNC, clear err, and clear the bit counter.
REQ-017 SYNC: the block SHALL accept 8 bits; if the received byte equals 8'hA5 it SHALL go to DATA, otherwise to ERROR.
REQ-018 DATA: the block SHALL accept 108 bits into a shadow register, in word order top[0..4], bottom[0..4], left[0..3], right[0..3], each word MSB-first, then go to CSUM.
REQ-019 CSUM: the block SHALL accept 8 bits, then go to CHECK.
REQ-020 CHECK: the block SHALL complete in one cycle with cfg_ready=0, computing the expected checksum as the sum modulo 256 of the 18 words, each zero-extended to 8 bits.
REQ-021 CHECK: if the checksum matches and every word has side field <= 3'd4, the block SHALL copy shadow to cfg_active, pulse done for 1 cycle, and return to IDLE.
REQ-022 CHECK: if the checksum mismatches or any side field is 5..7, the block SHALL go to ERROR and leave cfg_active unchanged.
REQ-023 ERROR: err=1, cfg_ready=0, busy=0; only cfg_start SHALL leave ERROR, going to SYNC.
REQ-024 busy SHALL be 1 in SYNC, DATA, CSUM and CHECK.
REQ-025 cfg_ready SHALL be 1 in SYNC, DATA and CSUM.
REQ-026 cfg_start while busy SHALL abort the load and restart at SYNC with the counter cleared; the shadow register is not cleared and cfg_active is unchanged.
REQ-027 If cfg_start coincides with a valid bit, cfg_start SHALL win and the bit SHALL be discarded.
REQ-028 Gaps in cfg_valid SHALL stall the FSM indefinitely; there is no timeout.
REQ-029 cfg_active SHALL change only in CHECK on success, taking effect the cycle after CHECK.
REQ-030 The bit counter SHALL be 7 bits wide and reset to 0 on every state transition.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously enter IDLE and clear cfg_active, shadow, counter and checksum to 0, with cfg_ready=0, busy=0, done=0, err=0; all-zero config means every pin is undriven.
REQ-032 A reset asserted mid-load SHALL discard the load in progress.
REQ-033 Reset SHALL be released synchronously by the surrounding logic; the block adds no synchronizer.

Structure
REQ-034 A shared package sbox_cfg_pkg SHALL hold the state enum, SYNC_BYTE=8'hA5, side codes (NONE=0, TOP=1, RIGHT=2, BOTTOM=3, LEFT=4) and the word-width constant.
REQ-035 The block SHALL contain one sub-module, sbox_word_check (combinational), which flags an illegal side field in any of the 18 shadow words.
REQ-036 cfg_active packing SHALL be LSB-first by word index (top[0] in bits [5:0], right[3] in bits [107:102]) so it maps directly onto the matrix config registers.

Verification
REQ-037 Nominal load: A5, 18 words each 6'b000_001, checksum 8'h12 -> done pulses once; cfg_active = 18 copies of 6'h01; err=0.
REQ-038 Bad sync: send 8'hA4 -> ERROR after the 8th bit, err=1, cfg_active still 0; DATA bits are ignored.
REQ-039 Bad checksum: valid frame with checksum 8'h13 -> err=1, no done, cfg_active retains the prior config.
REQ-040 Illegal side: word bottom[2]=6'b000_101 with correct checksum -> err=1, cfg_active unchanged.
REQ-041 Abort: cfg_start after 50 DATA bits, then a full valid frame -> exactly one done; cfg_active equals the second frame.
REQ-042 Stall and reset: cfg_valid toggling 1/0 randomly completes correctly; rst_n low mid-DATA -> all outputs 0 asynchronously and state IDLE.
